bram_bank_router: RTL and testbench
===================================

BRAM_BANK_ROUTER -- requirements
Module: bram_bank_router

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- N_BANKS, 25, number of BRAM banks (1..64).
- DATA_W, 32, bank data width (multiple of 8).
- ADDR_W, 32, address width.
- BANK_LSB, 12, lowest address bit of the bank field.
- BANK_W, 8, bank field width.
- BASE_BANK, 0, bank-field value that maps to bank 0.
- RD_LAT, 1, BRAM read latency in cycles (1..4).
- OUT_REG, 0, 1 adds one output register stage.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, sole clock.
- rst_n, in, 1, asynchronous active-low reset.
- addr, in, ADDR_W, access address.
- bram_en, in, 1, access strobe.
- bram_we, in, DATA_W/8, byte write enables.
- bram_en_out, out, N_BANKS, per-bank enable.
- bram_we_out, out, N_BANKS*DATA_W/8, per-bank byte write enables.
- bram_data_in, in, N_BANKS*DATA_W, bank k occupies bits [k*DATA_W +: DATA_W].
- bram_data_out, out, DATA_W, routed read data.
- rd_valid, out, 1, bram_data_out is valid this cycle.
- err_clr, in, 1, clears the error state.
- addr_err, out, 1, sticky out-of-range flag.
- err_addr, out, ADDR_W, first offending address.
- err_cnt, out, 16, saturating out-of-range access count.
REQ-003 There SHALL be one clock; reset is asynchronous and active-low (clk, rst_n).

Function
REQ-004 Decode: sel = addr[BANK_LSB +: BANK_W] - BASE_BANK; in_range = (field >= BASE_BANK) and (sel < N_BANKS).
REQ-005 bram_en_out[k] SHALL equal bram_en && in_range && sel==k, combinationally, with zero added latency.
REQ-006 bram_we_out bank k slice SHALL equal bram_we when bram_en_out[k] is 1, otherwise zero.
REQ-007 A read is bram_en=1 with bram_we all zero. Each read SHALL push {valid, in_range, sel} into an RD_LAT-stage shift pipeline. One read per cycle SHALL be accepted, with no back-pressure.
REQ-008 OUT_REG=0: rd_valid SHALL equal the tail valid bit, exactly RD_LAT cycles after the read strobe.
REQ-009 OUT_REG=1: rd_valid SHALL assert RD_LAT+1 cycles after the read strobe.
REQ-010 While rd_valid=1, bram_data_out SHALL equal the bank slice selected by the tail sel, or 0 if the tail in_range=0. While rd_valid=0, bram_data_out SHALL be 0.
REQ-011 Bank selection for returned data SHALL use the sel captured at issue time, not the current addr. Back-to-back reads to different banks SHALL each return their own bank's data.
REQ-012 Writes SHALL not enter the pipeline and SHALL produce no rd_valid.
REQ-013 Any bram_en=1 with in_range=0 is an error. On an error, addr_err SHALL be set, err_cnt SHALL increment (saturating at 16'hFFFF), and if addr_err was 0, err_addr SHALL capture addr.
REQ-014 err_clr=1 SHALL zero addr_err, err_addr and err_cnt on the next edge.
REQ-015 If err_clr and an error occur in the same cycle, the error SHALL win: addr_err=1, err_cnt=1, err_addr=current addr.

Reset
REQ-016 rst_n low SHALL immediately clear the pipeline, rd_valid, bram_data_out register, addr_err, err_addr and err_cnt to 0.
REQ-017 Reads in flight at reset SHALL be dropped, with no rd_valid after deassertion.
REQ-018 bram_en_out and bram_we_out are combinational and SHALL follow their inputs during reset.

Structure
REQ-019 The read-tracking pipeline SHALL be one sub-module, rd_tag_pipe, parameterised by depth and tag width.
REQ-020 A shared package SHALL hold the derived constants (SEL_W = clog2(N_BANKS), BE_W = DATA_W/8) and the pipeline tag record type {valid, in_range, sel}.

Verification
REQ-021 Defaults, read addr 0x0000_3000, bank 3 driving 0xA5A5_0003 -> bram_en_out=0x0000008, rd_valid and data 0xA5A5_0003 one cycle later.
REQ-022 RD_LAT=2, reads to banks 0,1,2 on consecutive cycles -> data 0,1,2 on cycles +2,+3,+4, rd_valid high for three cycles.
REQ-023 Read addr 0x0001_9000 (bank field 0x19) -> all enables 0, rd_valid with data 0, addr_err=1, err_addr=0x0001_9000, err_cnt=1.
REQ-024 Errors at 0x1A000 then 0x1B000, then err_clr together with a third error at 0x1C000 -> err_cnt=1, err_addr=0x0001_C000.
REQ-025 Write bram_we=4'b0101 to bank 24 -> only bank 24's we slice is 0101, no rd_valid.
REQ-026 rst_n pulsed low one cycle after a read with RD_LAT=3 -> no rd_valid ever, all registered outputs 0.

Source files
------------

// File: rtl/bram_bank_router_pkg.sv
// Shared definitions for the BRAM bank router.
//   - sel_w_f / be_w_f : derive the bank-select width and byte-enable width
//     from the instance parameters (N_BANKS, DATA_W).
//   - SEL_W / BE_W     : the same constants for the default configuration.
//   - rd_tag_t         : tag carried down the read-tracking pipeline
//                        {valid, in_range, sel}.
package bram_bank_router_pkg;

  // Widest bank select that is ever needed (N_BANKS <= 64).
  localparam int TAG_SEL_W = 6;

  function automatic int sel_w_f(input int n_banks);
    return (n_banks <= 1) ? 1 : $clog2(n_banks);
  endfunction

  function automatic int be_w_f(input int data_w);
    return data_w / 8;
  endfunction

  localparam int SEL_W = sel_w_f(25);
  localparam int BE_W  = be_w_f(32);

  typedef struct packed {
    logic                 valid;
    logic                 in_range;
    logic [TAG_SEL_W-1:0] sel;
  } rd_tag_t;

  localparam int TAG_W = $bits(rd_tag_t);

endpackage

// File: rtl/bram_bank_router_rd_tag_pipe.sv
// rd_tag_pipe: fixed-depth shift pipeline for read tags.
// A tag is presented every cycle (valid=0 when nothing was issued) and
// emerges at out_tag exactly DEPTH clock edges later.
//   clk, rst_n : clock, asynchronous active-low reset (flushes all stages)
//   in_tag     : tag entering stage 0
//   out_tag    : tag at the tail stage
module rd_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] out_tag
);

  logic [TAG_W-1:0] stages [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign out_tag = stages[DEPTH-1];

endmodule

// File: rtl/bram_bank_router.sv
// bram_bank_router: decodes a bank field from the access address, fans the
// strobe and byte enables out to one of N_BANKS BRAMs, and routes the read
// data of the selected bank back once the BRAM read latency has elapsed.
// Out-of-range accesses are flagged, counted and the first address kept.
//   clk, rst_n            : clock, asynchronous active-low reset
//   addr, bram_en, bram_we: access address, strobe, byte write enables
//   bram_en_out/we_out    : per-bank strobes / byte enables (combinational)
//   bram_data_in          : bank k read data at [k*DATA_W +: DATA_W]
//   bram_data_out,rd_valid: routed read data and its qualifier
//   err_clr               : clears the error state
//   addr_err,err_addr,err_cnt : sticky flag, first bad address, sat. count
//
// Handshake: there is no back-pressure. A read (bram_en=1, bram_we=0) is
// accepted every cycle it is strobed; rd_valid is a single-cycle qualifier
// for bram_data_out and bram_data_out is 0 whenever rd_valid is 0.
module bram_bank_router
  import bram_bank_router_pkg::*;
#(
  parameter int N_BANKS   = 25,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int BANK_LSB  = 12,
  parameter int BANK_W    = 8,
  parameter int BASE_BANK = 0,
  parameter int RD_LAT    = 1,
  parameter int OUT_REG   = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_W-1:0]              addr,
  input  logic                           bram_en,
  input  logic [DATA_W/8-1:0]            bram_we,
  output logic [N_BANKS-1:0]             bram_en_out,
  output logic [N_BANKS*(DATA_W/8)-1:0]  bram_we_out,
  input  logic [N_BANKS*DATA_W-1:0]      bram_data_in,
  output logic [DATA_W-1:0]              bram_data_out,
  output logic                           rd_valid,
  input  logic                           err_clr,
  output logic                           addr_err,
  output logic [ADDR_W-1:0]              err_addr,
  output logic [15:0]                    err_cnt
);

  localparam int BEW = be_w_f(DATA_W);

  logic [BANK_W-1:0] field;
  logic [BANK_W-1:0] sel;
  logic              in_range;
  logic              access_err;
  rd_tag_t           push_tag;
  rd_tag_t           tail_tag;
  logic [TAG_W-1:0]  tail_bits;
  logic [DATA_W-1:0] tail_data;

  // Decode. The subtraction wraps for fields below BASE_BANK, so the
  // lower bound is checked on the raw field.
  assign field    = addr[BANK_LSB +: BANK_W];
  assign sel      = field - BANK_W'(BASE_BANK);
  assign in_range = (field >= BANK_W'(BASE_BANK)) && (32'(sel) < 32'(N_BANKS));

  always_comb begin
    bram_en_out = '0;
    bram_we_out = '0;
    for (int k = 0; k < N_BANKS; k++) begin
      if (bram_en && in_range && (sel == BANK_W'(k))) begin
        bram_en_out[k]             = 1'b1;
        bram_we_out[k*BEW +: BEW]  = bram_we;
      end
    end
  end

  // Every cycle pushes a tag; only reads carry valid=1. Out-of-range reads
  // still travel so the requester sees a (zero-data) response.
  always_comb begin
    push_tag          = '0;
    push_tag.valid    = bram_en && (bram_we == '0);
    push_tag.in_range = in_range;
    push_tag.sel      = TAG_SEL_W'(sel);
  end

  rd_tag_pipe #(
    .DEPTH (RD_LAT),
    .TAG_W (TAG_W)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_tag  (push_tag),
    .out_tag (tail_bits)
  );

  assign tail_tag = rd_tag_t'(tail_bits);

  // Route with the sel captured at issue time, never the live address.
  always_comb begin
    tail_data = '0;
    if (tail_tag.valid && tail_tag.in_range) begin
      for (int k = 0; k < N_BANKS; k++) begin
        if (tail_tag.sel == TAG_SEL_W'(k)) tail_data = bram_data_in[k*DATA_W +: DATA_W];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_valid      <= 1'b0;
          bram_data_out <= '0;
        end else begin
          rd_valid      <= tail_tag.valid;
          bram_data_out <= tail_data;
        end
      end
    end else begin : g_out_comb
      assign rd_valid      = tail_tag.valid;
      assign bram_data_out = tail_data;
    end
  endgenerate

  // Error tracking. A simultaneous clear and error restarts the record
  // from this error rather than dropping it.
  assign access_err = bram_en && !in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err <= 1'b0;
      err_addr <= '0;
      err_cnt  <= '0;
    end else if (access_err) begin
      addr_err <= 1'b1;
      if (err_clr)                 err_cnt <= 16'd1;
      else if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      if (err_clr || !addr_err)    err_addr <= addr;
    end else if (err_clr) begin
      addr_err <= 1'b0;
      err_addr <= '0;
      err_cnt  <= '0;
    end
  end

endmodule

// File: tb/tb_bram_bank_router.sv
// Bench for bram_bank_router. Three instances share the stimulus:
// default (RD_LAT=1), RD_LAT=2, and RD_LAT=3 with OUT_REG=1 (4 cycles).
module tb_bram_bank_router;

  localparam int NB  = 25;
  localparam int DW  = 32;
  localparam int BEW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0]        addr;
  logic               bram_en;
  logic [BEW-1:0]     bram_we;
  logic               err_clr;
  logic [NB*DW-1:0]   bram_data_in;

  logic [NB-1:0]      en_out_1, en_out_2, en_out_3;
  logic [NB*BEW-1:0]  we_out_1, we_out_2, we_out_3;
  logic [DW-1:0]      dout_1, dout_2, dout_3;
  logic               rv_1, rv_2, rv_3;
  logic               aerr_1, aerr_2, aerr_3;
  logic [31:0]        eaddr_1, eaddr_2, eaddr_3;
  logic [15:0]        ecnt_1, ecnt_2, ecnt_3;

  bram_bank_router u_l1 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .bram_en(bram_en), .bram_we(bram_we),
    .bram_en_out(en_out_1), .bram_we_out(we_out_1), .bram_data_in(bram_data_in),
    .bram_data_out(dout_1), .rd_valid(rv_1), .err_clr(err_clr),
    .addr_err(aerr_1), .err_addr(eaddr_1), .err_cnt(ecnt_1));

  bram_bank_router #(.RD_LAT(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .bram_en(bram_en), .bram_we(bram_we),
    .bram_en_out(en_out_2), .bram_we_out(we_out_2), .bram_data_in(bram_data_in),
    .bram_data_out(dout_2), .rd_valid(rv_2), .err_clr(err_clr),
    .addr_err(aerr_2), .err_addr(eaddr_2), .err_cnt(ecnt_2));

  bram_bank_router #(.RD_LAT(3), .OUT_REG(1)) u_l3 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .bram_en(bram_en), .bram_we(bram_we),
    .bram_en_out(en_out_3), .bram_we_out(we_out_3), .bram_data_in(bram_data_in),
    .bram_data_out(dout_3), .rd_valid(rv_3), .err_clr(err_clr),
    .addr_err(aerr_3), .err_addr(eaddr_3), .err_cnt(ecnt_3));

  // scoreboard: entries are {due_cycle[31:0], data[31:0]}
  logic [63:0] exp_q1[$];
  logic [63:0] exp_q2[$];
  logic [63:0] exp_q3[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // error-state model
  logic        m_err;
  logic [31:0] m_addr;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pipe(input int idx, input logic v, input logic [31:0] d);
    logic [63:0] head;
    logic        ev;
    logic [31:0] ed;
    ev = 1'b0;
    ed = '0;
    case (idx)
      1: begin
        while (exp_q1.size() > 0 && int'(exp_q1[0][63:32]) < cyc) head = exp_q1.pop_front();
        if (exp_q1.size() > 0 && int'(exp_q1[0][63:32]) == cyc) begin
          head = exp_q1.pop_front(); ev = 1'b1; ed = head[31:0];
        end
      end
      2: begin
        while (exp_q2.size() > 0 && int'(exp_q2[0][63:32]) < cyc) head = exp_q2.pop_front();
        if (exp_q2.size() > 0 && int'(exp_q2[0][63:32]) == cyc) begin
          head = exp_q2.pop_front(); ev = 1'b1; ed = head[31:0];
        end
      end
      default: begin
        while (exp_q3.size() > 0 && int'(exp_q3[0][63:32]) < cyc) head = exp_q3.pop_front();
        if (exp_q3.size() > 0 && int'(exp_q3[0][63:32]) == cyc) begin
          head = exp_q3.pop_front(); ev = 1'b1; ed = head[31:0];
        end
      end
    endcase
    chk($sformatf("rd_valid_l%0d cyc%0d", idx, cyc), 128'(v), 128'(ev));
    chk($sformatf("data_l%0d cyc%0d", idx, cyc), 128'(d), 128'(ed));
  endtask

  task automatic check_err();
    chk($sformatf("addr_err cyc%0d", cyc), 128'(aerr_1), 128'(m_err));
    chk($sformatf("err_addr cyc%0d", cyc), 128'(eaddr_1), 128'(m_addr));
    chk($sformatf("err_cnt cyc%0d", cyc), 128'(ecnt_1), 128'(m_cnt));
  endtask

  // driver: apply one cycle of stimulus, check the combinational fan-out,
  // push expected reads, clock, then check registered behaviour.
  task automatic drive(input logic [31:0] a, input logic en, input logic [3:0] we,
                       input logic clr);
    logic [7:0]        fld;
    int                s;
    logic              inr;
    logic [NB-1:0]     een;
    logic [NB*BEW-1:0] ewe;
    logic [31:0]       ed;
    addr = a; bram_en = en; bram_we = we; err_clr = clr;
    #1;
    fld = a[19:12];
    s   = int'(fld);
    inr = (s < NB);
    een = '0;
    ewe = '0;
    if (en && inr) begin
      een[s]          = 1'b1;
      ewe[s*BEW +: BEW] = we;
    end
    chk($sformatf("bram_en_out a=%0h", a), 128'(en_out_1), 128'(een));
    chk($sformatf("bram_we_out a=%0h", a), 128'(we_out_1), 128'(ewe));
    if (en && we == 4'b0000) begin
      ed = inr ? (32'hA5A5_0000 | 32'(s)) : 32'h0;
      exp_q1.push_back({32'(cyc + 1), ed});
      exp_q2.push_back({32'(cyc + 2), ed});
      exp_q3.push_back({32'(cyc + 4), ed});
    end
    if (rst_n) begin
      if (en && !inr) begin
        m_cnt = clr ? 16'd1 : ((m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1);
        if (clr || !m_err) m_addr = a;
        m_err = 1'b1;
      end else if (clr) begin
        m_err = 1'b0; m_addr = '0; m_cnt = '0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_pipe(1, rv_1, dout_1);
    check_pipe(2, rv_2, dout_2);
    check_pipe(3, rv_3, dout_3);
    check_err();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(32'h0, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic check_all_reg_zero(input string tag);
    chk({tag, " rv1"}, 128'(rv_1), 128'(0));
    chk({tag, " rv2"}, 128'(rv_2), 128'(0));
    chk({tag, " rv3"}, 128'(rv_3), 128'(0));
    chk({tag, " dout1"}, 128'(dout_1), 128'(0));
    chk({tag, " dout3"}, 128'(dout_3), 128'(0));
    chk({tag, " addr_err"}, 128'(aerr_1), 128'(0));
    chk({tag, " err_addr"}, 128'(eaddr_1), 128'(0));
    chk({tag, " err_cnt"}, 128'(ecnt_1), 128'(0));
  endtask

  initial begin
    for (int k = 0; k < NB; k++) bram_data_in[k*DW +: DW] = 32'hA5A5_0000 | 32'(k);
    rst_n = 1'b0; addr = '0; bram_en = 1'b0; bram_we = '0; err_clr = 1'b0;
    m_err = 1'b0; m_addr = '0; m_cnt = '0;
    #3;
    check_all_reg_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // single read to bank 3
    drive(32'h0000_3000, 1'b1, 4'b0000, 1'b0);
    idle(4);

    // back-to-back reads to banks 0,1,2
    drive(32'h0000_0000, 1'b1, 4'b0000, 1'b0);
    drive(32'h0000_1000, 1'b1, 4'b0000, 1'b0);
    drive(32'h0000_2000, 1'b1, 4'b0000, 1'b0);
    idle(5);

    // out-of-range read (field 0x19)
    drive(32'h0001_9000, 1'b1, 4'b0000, 1'b0);
    idle(4);

    // more errors keep the first address, then clear collides with an error
    drive(32'h0001_A000, 1'b1, 4'b0000, 1'b0);
    drive(32'h0001_B000, 1'b1, 4'b0000, 1'b0);
    drive(32'h0001_C000, 1'b1, 4'b0000, 1'b1);
    drive(32'h0000_0000, 1'b0, 4'b0000, 1'b1);
    idle(4);

    // write to last bank: fan-out only, no response
    drive(32'h0001_8000, 1'b1, 4'b0101, 1'b0);
    drive(32'h0001_8ABC, 1'b1, 4'b1111, 1'b0);
    idle(5);

    // random mix of reads, writes, idles and out-of-range accesses
    for (int i = 0; i < 40; i++) begin
      logic [7:0]  b;
      logic [11:0] lo;
      logic [3:0]  w;
      b  = 8'($urandom_range(0, 27));
      lo = 12'($urandom_range(0, 4095));
      w  = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      drive({12'h000, b, lo}, ($urandom_range(0, 3) != 0), w, ($urandom_range(0, 15) == 0));
    end
    idle(5);

    // reset one cycle after a read: in-flight reads must vanish
    drive(32'h0000_5000, 1'b1, 4'b0000, 1'b0);
    rst_n = 1'b0;
    #1;
    check_all_reg_zero("async reset");
    exp_q1.delete(); exp_q2.delete(); exp_q3.delete();
    m_err = 1'b0; m_addr = '0; m_cnt = '0;
    idle(1);
    rst_n = 1'b1;
    idle(6);

    chk("q1 drained", 128'(exp_q1.size()), 128'(0));
    chk("q2 drained", 128'(exp_q2.size()), 128'(0));
    chk("q3 drained", 128'(exp_q3.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
